// File: rtl/riscv_core_mem_arbiter_pkg.sv
// Shared types and constants for the core memory arbiter: vc memory message
// sizing, arbiter port identifiers and the reset priority.
`ifndef VC_MEM_REQ_MSG_SZ
`define VC_MEM_REQ_MSG_SZ(a_, d_) (1 + (a_) + $clog2((d_) / 8) + (d_))
`endif
`ifndef VC_MEM_RESP_MSG_SZ
`define VC_MEM_RESP_MSG_SZ(d_) (1 + $clog2((d_) / 8) + (d_))
`endif

package riscv_core_mem_arbiter_pkg;

    localparam logic ARB_PORT_IMEM  = 1'b0;
    localparam logic ARB_PORT_DMEM  = 1'b1;
    // Data port wins the first tie after reset.
    localparam logic ARB_RESET_PRIO = ARB_PORT_DMEM;

    // Request message: {type, addr, len, data}; len encodes bytes in a word.
    function automatic int vc_mem_req_msg_sz(input int addr_sz, input int data_sz);
        return 1 + addr_sz + $clog2(data_sz / 8) + data_sz;
    endfunction

    // Response message: {type, len, data}.
    function automatic int vc_mem_resp_msg_sz(input int data_sz);
        return 1 + $clog2(data_sz / 8) + data_sz;
    endfunction

endpackage

// File: rtl/riscv_core_mem_arbiter_order_queue.sv
// In-order queue of 1-bit source port IDs for outstanding memory requests.
// Latency: head visible combinationally; push/pop take effect at the next edge.
// Backpressure: pushes while full and pops while empty are ignored.
module riscv_core_mem_arbiter_order_queue
    import riscv_core_mem_arbiter_pkg::*;
#(
    parameter int p_depth = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_vld,
    input  logic                       push_dat,
    input  logic                       pop_vld,
    output logic                       head_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(p_depth):0]   count
);

    localparam int c_ptr_sz = $clog2(p_depth);

    logic [p_depth-1:0]  slots;
    logic [c_ptr_sz-1:0] wr_ptr;
    logic [c_ptr_sz-1:0] rd_ptr;
    logic [c_ptr_sz:0]   cnt;
    logic                do_push;
    logic                do_pop;

    assign full     = (cnt == (c_ptr_sz + 1)'(p_depth));
    assign empty    = (cnt == '0);
    assign count    = cnt;
    assign head_dat = slots[rd_ptr];
    assign do_push  = push_vld & ~full;
    assign do_pop   = pop_vld & ~empty;

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                slots[wr_ptr] <= push_dat;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/riscv_core_mem_arbiter.sv
// Two-port round-robin arbiter onto a single memory port with in-order response routing.
// Latency: zero added cycles on requests and responses (combinational grant and routing).
// Backpressure: requests stall when memory is not ready or p_max_outstanding requests are in flight.
module riscv_core_mem_arbiter
    import riscv_core_mem_arbiter_pkg::*;
#(
    parameter int p_max_outstanding = 4,
    parameter int p_addr_sz         = 32,
    parameter int p_data_sz         = 32,
    localparam int c_req_sz         = vc_mem_req_msg_sz(p_addr_sz, p_data_sz),
    localparam int c_resp_sz        = vc_mem_resp_msg_sz(p_data_sz),
    localparam int c_cnt_sz         = $clog2(p_max_outstanding) + 1
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic [c_req_sz-1:0]  req0_msg,
    input  logic                 req0_val,
    output logic                 req0_rdy,
    output logic [c_resp_sz-1:0] resp0_msg,
    output logic                 resp0_val,

    input  logic [c_req_sz-1:0]  req1_msg,
    input  logic                 req1_val,
    output logic                 req1_rdy,
    output logic [c_resp_sz-1:0] resp1_msg,
    output logic                 resp1_val,

    output logic [c_req_sz-1:0]  memreq_msg,
    output logic                 memreq_val,
    input  logic                 memreq_rdy,
    input  logic [c_resp_sz-1:0] memresp_msg,
    input  logic                 memresp_val,

    output logic [c_cnt_sz-1:0]  outstanding,
    output logic                 err_unexp_resp
);

    logic prio_q;
    logic prio_d;
    logic grant_vld;
    logic grant_port;
    logic full;
    logic empty;
    logic head_port;
    logic accept;
    logic resp_pop;
    logic err_q;

    always_comb begin
        grant_vld  = 1'b0;
        grant_port = ARB_PORT_DMEM;
        if (prio_q == ARB_PORT_DMEM) begin
            if (req1_val) begin
                grant_vld  = 1'b1;
                grant_port = ARB_PORT_DMEM;
            end else if (req0_val) begin
                grant_vld  = 1'b1;
                grant_port = ARB_PORT_IMEM;
            end
        end else begin
            if (req0_val) begin
                grant_vld  = 1'b1;
                grant_port = ARB_PORT_IMEM;
            end else if (req1_val) begin
                grant_vld  = 1'b1;
                grant_port = ARB_PORT_DMEM;
            end
        end
    end

    // Full is judged on registered state only, so a same-cycle response
    // never opens a combinational path back to the request side.
    assign memreq_val = (req0_val | req1_val) & ~full;
    assign memreq_msg = (grant_vld && grant_port == ARB_PORT_IMEM) ? req0_msg : req1_msg;
    assign req0_rdy   = grant_vld & (grant_port == ARB_PORT_IMEM) & memreq_rdy & ~full;
    assign req1_rdy   = grant_vld & (grant_port == ARB_PORT_DMEM) & memreq_rdy & ~full;
    assign accept     = memreq_val & memreq_rdy;

    always_comb begin
        prio_d = prio_q;
        if (accept) begin
            prio_d = ~grant_port;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q <= ARB_RESET_PRIO;
        end else begin
            prio_q <= prio_d;
        end
    end

    riscv_core_mem_arbiter_order_queue #(
        .p_depth (p_max_outstanding)
    ) u_order_queue (
        .clk      (clk),
        .reset    (reset),
        .push_vld (accept),
        .push_dat (grant_port),
        .pop_vld  (resp_pop),
        .head_dat (head_port),
        .full     (full),
        .empty    (empty),
        .count    (outstanding)
    );

    assign resp_pop  = memresp_val & ~empty;
    assign resp0_val = resp_pop & (head_port == ARB_PORT_IMEM);
    assign resp1_val = resp_pop & (head_port == ARB_PORT_DMEM);
    assign resp0_msg = memresp_msg;
    assign resp1_msg = memresp_msg;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (memresp_val && empty) begin
            err_q <= 1'b1;
        end
    end

    assign err_unexp_resp = err_q;

endmodule

// File: tb/tb_riscv_core_mem_arbiter.sv
// Directed bench for riscv_core_mem_arbiter with a small latency-programmable memory model.
module tb_riscv_core_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [66:0] req0_msg, req1_msg, memreq_msg;
    logic        req0_val, req0_rdy, req1_val, req1_rdy;
    logic [34:0] resp0_msg, resp1_msg, memresp_msg;
    logic        resp0_val, resp1_val;
    logic        memreq_val, memreq_rdy, memresp_val;
    logic [2:0]  outstanding;
    logic        err_unexp_resp;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [34:0] msg;
        int          due;
    } mem_ent_t;

    mem_ent_t mq[$];
    bit       mem_en;
    int       mem_lat;
    int       cyc = 0;

    always #5 clk = ~clk;

    riscv_core_mem_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .req0_msg       (req0_msg),
        .req0_val       (req0_val),
        .req0_rdy       (req0_rdy),
        .resp0_msg      (resp0_msg),
        .resp0_val      (resp0_val),
        .req1_msg       (req1_msg),
        .req1_val       (req1_val),
        .req1_rdy       (req1_rdy),
        .resp1_msg      (resp1_msg),
        .resp1_val      (resp1_val),
        .memreq_msg     (memreq_msg),
        .memreq_val     (memreq_val),
        .memreq_rdy     (memreq_rdy),
        .memresp_msg    (memresp_msg),
        .memresp_val    (memresp_val),
        .outstanding    (outstanding),
        .err_unexp_resp (err_unexp_resp)
    );

    task automatic chk(input string tag, input logic [66:0] got, input logic [66:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [66:0] mk_req(input logic [31:0] addr);
        return {1'b0, addr, 2'b00, 32'h0};
    endfunction

    // Memory answers with data = addr + 0x1000.
    function automatic logic [34:0] mk_resp(input logic [66:0] req);
        return {req[66], req[33:32], req[65:34] + 32'h1000};
    endfunction

    task automatic settle();
        #1;
    endtask

    // Samples the accept before the edge, then advances the memory model.
    task automatic tick();
        bit          acc;
        logic [66:0] amsg;
        mem_ent_t    e;
        acc  = memreq_val & memreq_rdy & ~reset;
        amsg = memreq_msg;
        @(posedge clk);
        #1;
        cyc++;
        if (mem_en) begin
            memresp_val = 1'b0;
            if (acc) begin
                e.msg = mk_resp(amsg);
                e.due = cyc + mem_lat - 1;
                mq.push_back(e);
            end
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                memresp_val = 1'b1;
                memresp_msg = mq[0].msg;
                void'(mq.pop_front());
            end
        end
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        req0_val    = 1'b0;
        req1_val    = 1'b0;
        memresp_val = 1'b0;
        mq.delete();
        tick();
        tick();
        reset       = 1'b0;
        memresp_val = 1'b0;
        mq.delete();
        settle();
    endtask

    int          exp_port [4] = '{1, 0, 1, 0};
    logic [31:0] exp_addr [4] = '{32'h400, 32'h300, 32'h401, 32'h301};
    bit          pat      [10] = '{0, 1, 1, 0, 0, 1, 1, 0, 0, 1};
    int          cnt0, cnt1, got_resps;
    int          exp_q[$];

    initial begin
        req0_msg    = '0;
        req1_msg    = '0;
        memreq_rdy  = 1'b1;
        memresp_msg = '0;
        mem_en      = 1'b1;
        mem_lat     = 1;
        do_reset();
        chk("rst_outstanding", 67'(outstanding), 67'd0);
        chk("rst_err", 67'(err_unexp_resp), 67'd0);
        chk("rst_memreq_val", 67'(memreq_val), 67'd0);
        chk("rst_resp_vals", 67'({resp0_val, resp1_val}), 67'd0);

        // Single port request, 1-cycle memory
        req0_msg = mk_req(32'h200);
        req0_val = 1'b1;
        settle();
        chk("t1_req0_rdy", 67'(req0_rdy), 67'd1);
        chk("t1_req1_rdy", 67'(req1_rdy), 67'd0);
        chk("t1_memreq_msg", memreq_msg, mk_req(32'h200));
        tick();
        req0_val = 1'b0;
        settle();
        chk("t1_resp0_val", 67'(resp0_val), 67'd1);
        chk("t1_resp0_data", 67'(resp0_msg[31:0]), 67'h1200);
        chk("t1_resp1_val", 67'(resp1_val), 67'd0);
        chk("t1_outstanding_1", 67'(outstanding), 67'd1);
        tick();
        chk("t1_outstanding_0", 67'(outstanding), 67'd0);
        chk("t1_resp0_idle", 67'(resp0_val), 67'd0);

        // Contention: grants and responses alternate 1,0,1,0
        do_reset();
        cnt0 = 0;
        cnt1 = 0;
        for (int i = 0; i < 5; i++) begin
            req0_val = (i < 4);
            req1_val = (i < 4);
            req0_msg = mk_req(32'h300 + 32'(cnt0));
            req1_msg = mk_req(32'h400 + 32'(cnt1));
            settle();
            if (i < 4) begin
                chk("t2_req1_rdy", 67'(req1_rdy), 67'(exp_port[i] == 1));
                chk("t2_req0_rdy", 67'(req0_rdy), 67'(exp_port[i] == 0));
            end
            if (i >= 1) begin
                chk("t2_resp_port", 67'({resp1_val, resp0_val}),
                    67'(exp_port[i-1] == 1 ? 2'b10 : 2'b01));
                chk("t2_resp_data", 67'(memresp_msg[31:0]), 67'(exp_addr[i-1] + 32'h1000));
            end
            if (req0_rdy) cnt0++;
            if (req1_rdy) cnt1++;
            tick();
        end
        chk("t2_outstanding_end", 67'(outstanding), 67'd0);

        // Backpressure: memory not ready for 3 cycles
        do_reset();
        req0_msg   = mk_req(32'h600);
        req1_msg   = mk_req(32'h700);
        req0_val   = 1'b1;
        req1_val   = 1'b1;
        memreq_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t3_rdys_low", 67'({req0_rdy, req1_rdy}), 67'd0);
            chk("t3_outstanding", 67'(outstanding), 67'd0);
            chk("t3_memreq_msg_port1", memreq_msg, mk_req(32'h700));
            tick();
        end
        memreq_rdy = 1'b1;
        settle();
        chk("t3_req1_rdy", 67'(req1_rdy), 67'd1);
        chk("t3_req0_rdy", 67'(req0_rdy), 67'd0);
        tick();
        req0_val = 1'b0;
        req1_val = 1'b0;
        tick();

        // Full: memory silent, port 0 issues 5 requests
        do_reset();
        mem_en   = 1'b0;
        req0_val = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req0_msg = mk_req(32'h800 + 32'(i));
            settle();
            chk("t4_accept", 67'(req0_rdy), 67'd1);
            tick();
        end
        req0_msg = mk_req(32'h804);
        settle();
        chk("t4_outstanding_full", 67'(outstanding), 67'd4);
        chk("t4_memreq_val_full", 67'(memreq_val), 67'd0);
        chk("t4_req0_rdy_full", 67'(req0_rdy), 67'd0);
        memresp_val = 1'b1;
        memresp_msg = mk_resp(mk_req(32'h800));
        settle();
        chk("t4_resp0_val", 67'(resp0_val), 67'd1);
        chk("t4_no_same_cycle_accept", 67'(req0_rdy), 67'd0);
        tick();
        memresp_val = 1'b0;
        settle();
        chk("t4_outstanding_3", 67'(outstanding), 67'd3);
        chk("t4_fifth_accept", 67'(req0_rdy), 67'd1);
        tick();
        chk("t4_outstanding_refull", 67'(outstanding), 67'd4);
        mem_en = 1'b1;

        // Wrap and order: 10 mixed requests, 3-cycle memory
        do_reset();
        mem_lat   = 3;
        got_resps = 0;
        exp_q.delete();
        for (int i = 0; i < 30; i++) begin
            req0_val = 1'b0;
            req1_val = 1'b0;
            if (i < 10) begin
                if (pat[i]) begin
                    req1_val = 1'b1;
                    req1_msg = mk_req(32'h500 + 32'(i));
                end else begin
                    req0_val = 1'b1;
                    req0_msg = mk_req(32'h500 + 32'(i));
                end
                exp_q.push_back(i);
            end
            settle();
            if (i < 10) begin
                chk("t5_accept", 67'(pat[i] ? req1_rdy : req0_rdy), 67'd1);
            end
            if (resp0_val || resp1_val) begin
                if (exp_q.size() == 0) begin
                    chk("t5_extra_resp", 67'({resp1_val, resp0_val}), 67'd0);
                end else begin
                    chk("t5_resp_port", 67'({resp1_val, resp0_val}),
                        67'(pat[exp_q[0]] ? 2'b10 : 2'b01));
                    chk("t5_resp_data", 67'(resp0_msg[31:0]),
                        67'(32'h1500 + 32'(exp_q[0])));
                    void'(exp_q.pop_front());
                    got_resps++;
                end
            end
            tick();
        end
        chk("t5_resp_count", 67'(got_resps), 67'd10);
        chk("t5_outstanding_end", 67'(outstanding), 67'd0);
        mem_lat = 1;

        // Unexpected response, sticky error, reset with requests in flight
        do_reset();
        mem_en      = 1'b0;
        memresp_val = 1'b1;
        memresp_msg = 35'h1234;
        settle();
        chk("t6_no_resp_val", 67'({resp0_val, resp1_val}), 67'd0);
        chk("t6_err_not_yet", 67'(err_unexp_resp), 67'd0);
        tick();
        memresp_val = 1'b0;
        settle();
        chk("t6_err_set", 67'(err_unexp_resp), 67'd1);
        req1_val = 1'b1;
        req1_msg = mk_req(32'h900);
        tick();
        req1_val = 1'b0;
        req0_val = 1'b1;
        req0_msg = mk_req(32'h904);
        tick();
        req0_val = 1'b0;
        settle();
        chk("t6_outstanding_2", 67'(outstanding), 67'd2);
        chk("t6_err_sticky", 67'(err_unexp_resp), 67'd1);
        do_reset();
        chk("t6_err_cleared", 67'(err_unexp_resp), 67'd0);
        chk("t6_outstanding_cleared", 67'(outstanding), 67'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
